// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage.
//   ALUOP_* : two-bit decoded ALUOp from the ID stage
//   FUNCT_* : R-type funct field values the stage understands
//   ALU_*   : operation select codes driven to the ALU
//   buf_state_e : occupancy states of the two-entry result buffer
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_result_buf.sv
// Two-entry FIFO holding ALU results until the MEM stage takes them.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : write data_i (ignored when full and not popping)
//   pop_i         : consume head entry (ignored when empty)
//   data_i        : payload to store
//   valid_o       : at least one entry held
//   full_o        : both entries held
//   data_o        : head entry, zero while empty
module alu_result_buf
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic          full_o,
  output logic [DW-1:0] data_o
);

  buf_state_e    state_q;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [DW-1:0] mem_q [2];

  logic push_ok;
  logic pop_ok;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i && (state_q != BUF_EMPTY);
  assign push_ok = push_i && ((state_q != BUF_TWO) || pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= BUF_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case (state_q)
        BUF_EMPTY: if (push_ok) state_q <= BUF_ONE;
        BUF_ONE: begin
          if (push_ok && !pop_ok)      state_q <= BUF_TWO;
          else if (!push_ok && pop_ok) state_q <= BUF_EMPTY;
        end
        BUF_TWO:   if (pop_ok && !push_ok) state_q <= BUF_ONE;
        default:   state_q <= BUF_EMPTY;
      endcase
    end
  end

  assign valid_o = (state_q != BUF_EMPTY);
  assign full_o  = (state_q == BUF_TWO);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end sitting directly upstream of the ALU.
// Registers decoded ops (ID/EX), decodes ALUOp/funct into ALU controls,
// and captures the ALU result into a two-entry buffer feeding MEM.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   in_valid_i/in_ready_o  : upstream handshake
//   in_aluop_i, in_funct_i : decoded control
//   in_a_i, in_b_i, in_rd_i: operands and destination register
//   alu_in1_o..alu_cin_o   : controls and operands to the ALU
//   alu_out_i, alu_cout_i  : ALU result and carry
//   out_valid_o/out_ready_i: downstream handshake
//   out_result_o, out_zero_o, out_cout_o, out_rd_o, out_illegal_o : result entry
// Configuration macro:
//   ALU_SLT_EN : when defined, funct 101010 executes slt; otherwise it is illegal.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_aluop_i,
  input  logic [5:0]        in_funct_i,
  input  logic [WIDTH-1:0]  in_a_i,
  input  logic [WIDTH-1:0]  in_b_i,
  input  logic [REG_AW-1:0] in_rd_i,
  output logic [WIDTH-1:0]  alu_in1_o,
  output logic [WIDTH-1:0]  alu_in2_o,
  output logic [1:0]        alu_op_o,
  output logic              alu_binvert_o,
  output logic              alu_cin_o,
  input  logic [WIDTH-1:0]  alu_out_i,
  input  logic              alu_cout_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_result_o,
  output logic              out_zero_o,
  output logic              out_cout_o,
  output logic [REG_AW-1:0] out_rd_o,
  output logic              out_illegal_o
);

  localparam int PW = WIDTH + REG_AW + 3;

  logic              s1_valid_q;
  logic [1:0]        s1_aluop_q;
  logic [5:0]        s1_funct_q;
  logic [WIDTH-1:0]  s1_a_q;
  logic [WIDTH-1:0]  s1_b_q;
  logic [REG_AW-1:0] s1_rd_q;

  logic [1:0]        dec_op;
  logic              dec_binv;
  logic              dec_cin;
  logic              dec_illegal;
  logic              dec_slt;

  logic              slt_ovf;
  logic [WIDTH-1:0]  res_result;
  logic              res_zero;
  logic              res_cout;

  logic              buf_valid;
  logic              buf_full;
  logic [PW-1:0]     buf_data;
  logic              pop;
  logic              advance;

  assign pop        = buf_valid && out_ready_i;
  assign advance    = s1_valid_q && (!buf_full || pop);
  assign in_ready_o = rst_ni && (!s1_valid_q || advance);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_aluop_q <= '0;
      s1_funct_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rd_q    <= '0;
    end else if (in_valid_i && in_ready_o) begin
      s1_valid_q <= 1'b1;
      s1_aluop_q <= in_aluop_i;
      s1_funct_q <= in_funct_i;
      s1_a_q     <= in_a_i;
      s1_b_q     <= in_b_i;
      s1_rd_q    <= in_rd_i;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Subtraction is a + ~b + 1, so every subtract path sets both binvert and Cin.
  // Empty or illegal S1 leaves the ALU controls at their quiet AND/0/0 value.
  always_comb begin
    dec_op      = ALU_AND;
    dec_binv    = 1'b0;
    dec_cin     = 1'b0;
    dec_illegal = 1'b0;
    dec_slt     = 1'b0;
    if (s1_valid_q) begin
      case (s1_aluop_q)
        ALUOP_ADD: dec_op = ALU_ADD;
        ALUOP_SUB: begin
          dec_op   = ALU_ADD;
          dec_binv = 1'b1;
          dec_cin  = 1'b1;
        end
        ALUOP_RTYPE: begin
          case (s1_funct_q)
            FUNCT_ADD: dec_op = ALU_ADD;
            FUNCT_SUB: begin
              dec_op   = ALU_ADD;
              dec_binv = 1'b1;
              dec_cin  = 1'b1;
            end
            FUNCT_AND: dec_op = ALU_AND;
            FUNCT_OR:  dec_op = ALU_OR;
`ifdef ALU_SLT_EN
            FUNCT_SLT: begin
              dec_op   = ALU_ADD;
              dec_binv = 1'b1;
              dec_cin  = 1'b1;
              dec_slt  = 1'b1;
            end
`endif
            default: dec_illegal = 1'b1;
          endcase
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  assign alu_in1_o     = s1_a_q;
  assign alu_in2_o     = s1_b_q;
  assign alu_op_o      = dec_op;
  assign alu_binvert_o = dec_binv;
  assign alu_cin_o     = dec_cin;

  // Signed less-than from the subtract: the sign of a-b is wrong exactly when it overflowed.
  assign slt_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                   (alu_out_i[WIDTH-1] != s1_a_q[WIDTH-1]);

  always_comb begin
    res_result = alu_out_i;
    if (dec_illegal) begin
      res_result = '0;
    end else if (dec_slt) begin
      res_result = {{(WIDTH-1){1'b0}}, alu_out_i[WIDTH-1] ^ slt_ovf};
    end
  end

  assign res_zero = !dec_illegal && (res_result == '0);
  assign res_cout = !dec_illegal && !dec_slt && (dec_op == ALU_ADD) && alu_cout_i;

  alu_result_buf #(
    .DW(PW)
  ) u_result_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (advance),
    .pop_i   (pop),
    .data_i  ({res_result, res_zero, res_cout, s1_rd_q, dec_illegal}),
    .valid_o (buf_valid),
    .full_o  (buf_full),
    .data_o  (buf_data)
  );

  assign out_valid_o = buf_valid;
  assign {out_result_o, out_zero_o, out_cout_o, out_rd_o, out_illegal_o} = buf_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// A behavioural ALU closes the loop; a queue-based model predicts every
// result entry and the handshake signals, checked on each falling edge.
// Honours ALU_SLT_EN the same way the design does.
module tb_alu_issue_stage;

  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_aluop;
  logic [5:0]    in_funct;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [RA-1:0] in_rd;
  logic [W-1:0]  alu_in1;
  logic [W-1:0]  alu_in2;
  logic [1:0]    alu_op;
  logic          alu_binvert;
  logic          alu_cin;
  logic [W-1:0]  alu_out;
  logic          alu_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero;
  logic          out_cout;
  logic [RA-1:0] out_rd;
  logic          out_illegal;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0]  result;
    logic          zero;
    logic          cout;
    logic [RA-1:0] rd;
    logic          illegal;
    int            acc;
  } exp_t;

  exp_t q[$];

  alu_issue_stage #(.WIDTH(W), .REG_AW(RA)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_aluop_i    (in_aluop),
    .in_funct_i    (in_funct),
    .in_a_i        (in_a),
    .in_b_i        (in_b),
    .in_rd_i       (in_rd),
    .alu_in1_o     (alu_in1),
    .alu_in2_o     (alu_in2),
    .alu_op_o      (alu_op),
    .alu_binvert_o (alu_binvert),
    .alu_cin_o     (alu_cin),
    .alu_out_i     (alu_out),
    .alu_cout_i    (alu_cout),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_result_o  (out_result),
    .out_zero_o    (out_zero),
    .out_cout_o    (out_cout),
    .out_rd_o      (out_rd),
    .out_illegal_o (out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // The ALU always produces the adder carry, even for AND/OR, so the stage must mask it.
  logic [W-1:0] alu_bsel;
  logic [W:0]   alu_sum;
  always_comb begin
    alu_bsel = alu_binvert ? ~alu_in2 : alu_in2;
    alu_sum  = {1'b0, alu_in1} + {1'b0, alu_bsel} + {{W{1'b0}}, alu_cin};
    case (alu_op)
      2'b00:   alu_out = alu_in1 & alu_bsel;
      2'b01:   alu_out = alu_in1 | alu_bsel;
      default: alu_out = alu_sum[W-1:0];
    endcase
    alu_cout = alu_sum[W];
  end

  function automatic exp_t predict(input logic [1:0] aluop, input logic [5:0] funct,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [RA-1:0] rd);
    exp_t e;
    e.rd      = rd;
    e.illegal = 1'b0;
    e.cout    = 1'b0;
    e.result  = '0;
    e.acc     = 0;
    case (aluop)
      2'b00: {e.cout, e.result} = {1'b0, a} + {1'b0, b};
      2'b01: begin e.result = a - b; e.cout = (a >= b); end
      2'b10: begin
        case (funct)
          6'h20: {e.cout, e.result} = {1'b0, a} + {1'b0, b};
          6'h22: begin e.result = a - b; e.cout = (a >= b); end
          6'h24: e.result = a & b;
          6'h25: e.result = a | b;
`ifdef ALU_SLT_EN
          6'h2A: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
          default: e.illegal = 1'b1;
        endcase
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.result = '0;
      e.cout   = 1'b0;
    end
    e.zero = !e.illegal && (e.result == '0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model process: head of queue must be on the outputs whenever it has left S1.
  bit exp_valid;
  bit exp_ready;
  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_valid = (q.size() > 0) && !((q.size() == 1) && (q[0].acc == cyc));
      exp_ready = rst_n && ((q.size() < 3) || (exp_valid && out_ready));
      checkOutput("mdl_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      checkOutput("mdl_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (exp_valid && out_valid === 1'b1) begin
        checkOutput("mdl_result", out_result, q[0].result);
        checkOutput("mdl_zero", {31'd0, out_zero}, {31'd0, q[0].zero});
        checkOutput("mdl_cout", {31'd0, out_cout}, {31'd0, q[0].cout});
        checkOutput("mdl_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        checkOutput("mdl_illegal", {31'd0, out_illegal}, {31'd0, q[0].illegal});
      end
      if (!rst_n) begin
        q.delete();
      end else begin
        if (out_valid === 1'b1 && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready === 1'b1) begin
          exp_t e;
          e = predict(in_aluop, in_funct, in_a, in_b, in_rd);
          e.acc = cyc + 1;
          q.push_back(e);
        end
      end
    end
  end

  // Drives one op starting just after a rising edge; returns just after its accepting edge.
  task automatic applyStimulus(input logic [1:0] aluop, input logic [5:0] funct,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [RA-1:0] rd, output int stalls);
    in_valid = 1'b1;
    in_aluop = aluop;
    in_funct = funct;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    stalls   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 50) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL accept_timeout actual=busy required=accepted");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic checkAlu(input string name, input logic [1:0] op, input logic binv, input logic cin,
                          input logic [W-1:0] a);
    @(negedge clk);
    checkOutput({name, "_alu_op"}, {30'd0, alu_op}, {30'd0, op});
    checkOutput({name, "_binv"}, {31'd0, alu_binvert}, {31'd0, binv});
    checkOutput({name, "_cin"}, {31'd0, alu_cin}, {31'd0, cin});
    checkOutput({name, "_in1"}, alu_in1, a);
  endtask

  task automatic expectHead(input string name, input logic [W-1:0] res, input logic z,
                            input logic c, input logic [RA-1:0] rd, input logic ill);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({name, "_result"}, out_result, res);
    checkOutput({name, "_zero"}, {31'd0, out_zero}, {31'd0, z});
    checkOutput({name, "_cout"}, {31'd0, out_cout}, {31'd0, c});
    checkOutput({name, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    checkOutput({name, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_aluop  = '0;
    in_funct  = '0;
    in_a      = '0;
    in_b      = '0;
    in_rd     = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_result", out_result, 32'd0);
    checkOutput("rst_alu_op", {30'd0, alu_op}, 32'd0);
    checkOutput("rst_alu_in1", alu_in1, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] add / beq / logic ops");
    applyStimulus(2'b10, 6'h20, 32'd5, 32'd7, 5'd1, st);
    checkAlu("add", 2'b10, 1'b0, 1'b0, 32'd5);
    expectHead("add", 32'd12, 1'b0, 1'b0, 5'd1, 1'b0);
    @(posedge clk); #1;

    applyStimulus(2'b01, 6'h00, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd2, st);
    checkAlu("beq", 2'b10, 1'b1, 1'b1, 32'hA5A5A5A5);
    expectHead("beq", 32'd0, 1'b1, 1'b1, 5'd2, 1'b0);
    @(posedge clk); #1;

    applyStimulus(2'b10, 6'h24, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd3, st);
    checkAlu("and", 2'b00, 1'b0, 1'b0, 32'hA5A5A5A5);
    expectHead("and", 32'd0, 1'b1, 1'b0, 5'd3, 1'b0);
    @(posedge clk); #1;

    applyStimulus(2'b10, 6'h25, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd4, st);
    checkAlu("or", 2'b01, 1'b0, 1'b0, 32'hA5A5A5A5);
    expectHead("or", 32'hFFFFFFFF, 1'b0, 1'b0, 5'd4, 1'b0);
    @(posedge clk); #1;

    applyStimulus(2'b10, 6'h24, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, st);
    expectHead("and_ones", 32'hFFFFFFFF, 1'b0, 1'b0, 5'd5, 1'b0);
    @(posedge clk); #1;

    applyStimulus(2'b10, 6'h22, 32'd3, 32'd9, 5'd6, st);
    expectHead("sub_neg", 32'hFFFFFFFA, 1'b0, 1'b0, 5'd6, 1'b0);
    @(posedge clk); #1;

    $display("[TB] illegal and slt");
    applyStimulus(2'b10, 6'h27, 32'd8, 32'd9, 5'd3, st);
    checkAlu("illegal", 2'b00, 1'b0, 1'b0, 32'd8);
    expectHead("illegal", 32'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    @(posedge clk); #1;

    applyStimulus(2'b00, 6'h27, 32'd1, 32'd1, 5'd4, st);
    expectHead("after_illegal", 32'd2, 1'b0, 1'b0, 5'd4, 1'b0);
    @(posedge clk); #1;

    applyStimulus(2'b11, 6'h20, 32'd1, 32'd1, 5'd9, st);
    expectHead("aluop11", 32'd0, 1'b0, 1'b0, 5'd9, 1'b1);
    @(posedge clk); #1;

    applyStimulus(2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd5, st);
`ifdef ALU_SLT_EN
    expectHead("slt", 32'd1, 1'b0, 1'b0, 5'd5, 1'b0);
`else
    expectHead("slt", 32'd0, 1'b0, 1'b0, 5'd5, 1'b1);
`endif
    @(posedge clk); #1;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 6'h00, 32'd100 + 32'(k), 32'd1, 5'(10 + k), st);
    end
    in_valid = 1'b1;
    in_aluop = 2'b00;
    in_a     = 32'd103;
    in_b     = 32'd1;
    in_rd    = 5'd13;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("bp_head_result", out_result, 32'd101);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_on_pop", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_order0", {27'd0, out_rd}, 32'd10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checkOutput("bp_order_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_order", {27'd0, out_rd}, 32'(10 + k));
    end
    @(posedge clk); #1;

    $display("[TB] throughput");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b10, 6'h20, 32'(k * 7), 32'(k), 5'(16 + k), st);
      checkOutput("thru_stall", 32'(st), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset mid-transfer");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 6'h00, 32'd50, 32'(k), 5'(20 + k), st);
    end
    in_valid = 1'b1;
    in_rd    = 5'd23;
    @(negedge clk);
    checkOutput("rst_mid_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mid_result", out_result, 32'd0);
    checkOutput("rst_mid_rd", {27'd0, out_rd}, 32'd0);
    checkOutput("rst_mid_alu_in1", alu_in1, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_rel_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(2'b10, 6'h20, 32'd40, 32'd2, 5'd7, st);
    expectHead("fresh", 32'd42, 1'b0, 1'b0, 5'd7, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
